// File: rtl/mem_requester.sv
// Load/store requester for the single-port word memory: sub-word loads with sign/zero
// extension, read-modify-write for sub-word stores. Optional MEM_REQUESTER_MISALIGN_TRAP_EN rejects misaligned/reserved accesses.
module mem_requester #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [1:0]                 req_size_i,
  input  logic                       req_unsigned_i,
  input  logic [$clog2(DEPTH)+1:0]   req_addr_i,
  input  logic [31:0]                req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [31:0]                rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       mem_read_en_o,
  output logic [$clog2(DEPTH)-1:0]   mem_read_pos_o,
  input  logic [31:0]                mem_read_data_i,
  input  logic                       mem_read_valid_i,
  output logic                       mem_write_en_o,
  output logic [$clog2(DEPTH)-1:0]   mem_write_pos_o,
  output logic [31:0]                mem_write_data_o
);
  localparam int ADDR_W = $clog2(DEPTH) + 2;
  localparam int POS_W  = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, uns_q, err_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q, rdata_q;
  logic [POS_W-1:0]    read_pos_q, write_pos_q;
  logic [31:0]         write_data_q;

  logic                accept, reject;
  logic [1:0]          size_eff;
  logic [31:0]         merged, shifted, extended;

  always_comb begin
`ifdef MEM_REQUESTER_MISALIGN_TRAP_EN
    size_eff = req_size_i;
    reject   = (req_size_i == 2'b11)
            || (req_size_i == 2'b01 && req_addr_i[0])
            || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
    size_eff = (req_size_i == 2'b11) ? 2'b10 : req_size_i;
    reject   = 1'b0;
`endif
  end

  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  // Lane merge for sub-word stores; half ignores addr[0], word ignores both low bits.
  always_comb begin
    merged = mem_read_data_i;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    shifted  = mem_read_data_i;
    extended = mem_read_data_i;
    case (size_q)
      2'b00: begin
        shifted  = mem_read_data_i >> {addr_q[1:0], 3'b000};
        extended = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        shifted  = mem_read_data_i >> {addr_q[1], 4'b0000};
        extended = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: extended = mem_read_data_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reject)                          state_d = S_RESP;
          else if (req_we_i && size_eff == 2'b10) state_d = S_WRITE;
          else                                 state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  if (mem_read_valid_i) state_d = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      read_pos_q   <= '0;
      write_pos_q  <= '0;
      write_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        err_q   <= reject;
        size_q  <= size_eff;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        rdata_q <= '0;
        if (!reject) begin
          if (req_we_i && size_eff == 2'b10) begin
            write_pos_q  <= req_addr_i[ADDR_W-1:2];
            write_data_q <= req_wdata_i;
          end else begin
            read_pos_q <= req_addr_i[ADDR_W-1:2];
          end
        end
      end
      if (state_q == S_WAIT && mem_read_valid_i) begin
        if (we_q) begin
          write_pos_q  <= addr_q[ADDR_W-1:2];
          write_data_q <= merged;
        end else begin
          rdata_q <= extended;
        end
      end
    end
  end

  // Strobes are gated by rst_i so a reset landing in READ/WRITE issues nothing.
  assign mem_read_en_o    = (state_q == S_READ) && !rst_i;
  assign mem_write_en_o   = (state_q == S_WRITE) && !rst_i;
  assign mem_read_pos_o   = read_pos_q;
  assign mem_write_pos_o  = write_pos_q;
  assign mem_write_data_o = write_data_q;
  assign rsp_valid_o      = (state_q == S_RESP) && !rst_i;
  assign rsp_rdata_o      = rsp_valid_o ? rdata_q : 32'h0;
`ifdef MEM_REQUESTER_MISALIGN_TRAP_EN
  assign rsp_err_o        = rsp_valid_o && err_q;
`else
  assign rsp_err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: directed vector table, reset-abort sequence, and random
// traffic against a byte-array reference memory with a variable-latency memory model.
module tb_mem_requester;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read_en, mem_write_en;
  logic [3:0]  mem_read_pos, mem_write_pos;
  logic [31:0] mem_read_data = '0, mem_write_data;
  logic        mem_read_valid = 1'b0;

  int total = 0;
  int bad = 0;

  mem_requester #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_read_en_o(mem_read_en), .mem_read_pos_o(mem_read_pos),
    .mem_read_data_i(mem_read_data), .mem_read_valid_i(mem_read_valid),
    .mem_write_en_o(mem_write_en), .mem_write_pos_o(mem_write_pos),
    .mem_write_data_o(mem_write_data)
  );

  always #5 clk = ~clk;

  // Memory model: valid arrives lat cycles after the read_en cycle.
  logic [31:0] mem [DEPTH];
  int          lat = 1;
  int          cnt = 0;
  logic [3:0]  rpos = '0;

  always @(posedge clk) begin
    mem_read_valid <= 1'b0;
    if (mem_write_en) mem[mem_write_pos] = mem_write_data;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mem_read_valid <= 1'b1;
        mem_read_data  <= mem[rpos];
      end
    end
    if (mem_read_en) begin
      rpos = mem_read_pos;
      if (lat == 1) begin
        mem_read_valid <= 1'b1;
        mem_read_data  <= mem[mem_read_pos];
      end else begin
        cnt = lat - 1;
      end
    end
  end

  // Reference memory kept as bytes.
  logic [7:0] ref_b [DEPTH*4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) ref_b[4*w+i] = v[8*i +: 8];
  endtask

  function automatic void ref_model(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [5:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic err,
                                    output int cyc, output int nrd, output int nwr);
    int sz, nb, base;
    logic [31:0] v;
    err = 1'b0;
`ifdef MEM_REQUESTER_MISALIGN_TRAP_EN
    if (size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00))
      err = 1'b1;
`endif
    rdata = 32'h0;
    if (err) begin
      cyc = 1; nrd = 0; nwr = 0;
      return;
    end
    sz   = (size == 2'b11) ? 2 : int'(size);
    nb   = 1 << sz;
    base = int'(addr) & ~(nb - 1);
    if (we) begin
      for (int i = 0; i < nb; i++) ref_b[base+i] = wdata[8*i +: 8];
      cyc = (nb == 4) ? 2 : 3 + lat;
      nrd = (nb == 4) ? 0 : 1;
      nwr = 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_b[base+i]) << (8*i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rdata = v;
      cyc = 2 + lat; nrd = 1; nwr = 0;
    end
  endfunction

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [5:0] addr, input logic [31:0] wdata,
                         input int exp_cyc, input int exp_nrd, input int exp_nwr,
                         output logic [31:0] rdata, output logic err);
    int k, nrd, nwr, rd_at, wr_at;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    k = 1; nrd = 0; nwr = 0; rd_at = 0; wr_at = 0;
    while (!rsp_valid && k < 40) begin
      if (mem_read_en) begin
        nrd++; rd_at = k;
        chk("read_pos", 32'(mem_read_pos), 32'(addr[5:2]));
      end
      if (mem_write_en) begin
        nwr++; wr_at = k;
        chk("write_pos", 32'(mem_write_pos), 32'(addr[5:2]));
      end
      @(negedge clk);
      k++;
    end
    chk("rsp_cycle", k, exp_cyc);
    chk("read_count", nrd, exp_nrd);
    chk("write_count", nwr, exp_nwr);
    if (exp_nrd == 1) chk("read_cycle", rd_at, 1);
    if (exp_nwr == 1) chk("write_cycle", wr_at, exp_cyc - 1);
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;
    int          cyc, nrd, nwr;
    logic        we, uns;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 6'h14, 32'h0000_0045, 32'h0,          32'h0,          32'h0000_0045, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 6'h14, 32'h0,         32'h0000_0045, 32'h0000_0045, 32'h0000_0045, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 6'h16, 32'h0000_00AB, 32'h1122_3344, 32'h0,          32'h11AB_3344, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 6'h17, 32'h0,         32'h80FF_0000, 32'hFFFF_FF80, 32'h80FF_0000, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 6'h17, 32'h0,         32'h80FF_0000, 32'h0000_0080, 32'h80FF_0000, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 6'h16, 32'h0,         32'h80FF_0000, 32'hFFFF_80FF, 32'h80FF_0000, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 6'h14, 32'h0,         32'h80FF_8001, 32'h0000_8001, 32'h80FF_8001, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 6'h12, 32'h1234_BEEF, 32'hAABB_CCDD, 32'h0,          32'hBEEF_CCDD, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 6'h10, 32'h0,         32'h0000_007F, 32'h0000_007F, 32'h0000_007F, 1'b0};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 6'h0F, 32'hFFFF_FF12, 32'h0,          32'h0,          32'h1200_0000, 1'b0};
`ifdef MEM_REQUESTER_MISALIGN_TRAP_EN
    vecs[10] = '{1'b0, 2'd2, 1'b0, 6'h15, 32'h0,         32'hCAFE_F00D, 32'h0,          32'hCAFE_F00D, 1'b1};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 6'h18, 32'h0,         32'h0102_0304, 32'h0,          32'h0102_0304, 1'b1};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 6'h13, 32'h0,         32'h8001_7FFF, 32'h0,          32'h8001_7FFF, 1'b1};
    vecs[13] = '{1'b1, 2'd1, 1'b0, 6'h21, 32'h0000_5566, 32'h0,          32'h0,          32'h0,          1'b1};
`else
    vecs[10] = '{1'b0, 2'd2, 1'b0, 6'h15, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 6'h18, 32'h0,         32'h0102_0304, 32'h0102_0304, 32'h0102_0304, 1'b0};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 6'h13, 32'h0,         32'h8001_7FFF, 32'hFFFF_8001, 32'h8001_7FFF, 1'b0};
    vecs[13] = '{1'b1, 2'd1, 1'b0, 6'h21, 32'h0000_5566, 32'h0,          32'h0,          32'h0000_5566, 1'b0};
`endif

    for (int w = 0; w < DEPTH; w++) set_word(w, 32'h0);

    // Reset: everything quiet, ready low while rst is high, high right after release.
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_outputs", {rsp_valid, rsp_err, mem_read_en, mem_write_en, 28'h0},
        32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_pos_data", {mem_read_pos, mem_write_pos, 24'h0} | mem_write_data, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Directed vectors, memory latency 1.
    lat = 1;
    for (int i = 0; i < 14; i++) begin
      set_word(int'(vecs[i].addr[5:2]), vecs[i].init);
      ref_model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                erd, eer, cyc, nrd, nwr);
      run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              cyc, nrd, nwr, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      @(negedge clk);
      chk($sformatf("vec%0d_word", i), mem[vecs[i].addr[5:2]], vecs[i].exp_word);
    end

    // Reset while waiting on read data during a byte store.
    lat = 3;
    set_word(5, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 6'h16; req_wdata = 32'h0000_00AB;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_read_en", 32'(mem_read_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd0);
    chk("abort_outputs", {rsp_valid, rsp_err, mem_read_en, mem_write_en, 28'h0}, 32'h0);
    chk("abort_rdata", rsp_rdata, 32'h0);
    chk("abort_pos_data", {mem_read_pos, mem_write_pos, 24'h0} | mem_write_data, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (mem_write_en || rsp_valid) chk("abort_quiet_in_reset", 32'd1, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_write_en || rsp_valid || mem_read_en) chk("abort_quiet_after", 32'd1, 32'd0);
    end
    chk("abort_mem_intact", mem[5], 32'h1122_3344);

    // Random traffic against the byte-level reference.
    for (int w = 0; w < DEPTH; w++) set_word(w, $urandom);
    for (int n = 0; n < 200; n++) begin
      lat   = $urandom_range(1, 3);
      we    = 1'($urandom);
      size  = 2'($urandom);
      uns   = 1'($urandom);
      addr  = 6'($urandom);
      wdata = $urandom;
      ref_model(we, size, uns, addr, wdata, erd, eer, cyc, nrd, nwr);
      run_req(we, size, uns, addr, wdata, cyc, nrd, nwr, rd, er);
      chk($sformatf("rand%0d_rdata", n), rd, erd);
      chk($sformatf("rand%0d_err", n), 32'(er), 32'(eer));
    end
    repeat (4) @(negedge clk);
    for (int w = 0; w < DEPTH; w++)
      chk($sformatf("final_word%0d", w), mem[w],
          {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
# mem_requester

Initiator side of the single-port `memory` read/write interface. It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake and drives `memory`'s enable/position/data ports. It waits for `read_valid`, extracts and sign-extends load data, and performs read-modify-write for sub-word stores. It sits between the core's execute stage and the word-addressed data memory.

## Interface
- `DEPTH`, default 16: number of 32-bit words in the attached memory. Word width is fixed at 32.
- `ADDR_W` (localparam), value `$clog2(DEPTH)+2`: byte-address width.

Ports:
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when high together with `req_valid_i`.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_unsigned_i` in 1: zero-extend load data. When low, loads sign-extend.
- `req_addr_i` in ADDR_W: byte address.
- `req_wdata_i` in 32: store data, taken from the low bytes.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 32: load result. Driven as 0 when `rsp_valid_o` is low, and for stores.
- `rsp_err_o` out 1: request rejected. Meaningful only with `rsp_valid_o`.
- `mem_read_en_o` out 1: to `memory.read_en_i`.
- `mem_read_pos_o` out $clog2(DEPTH): to `memory.read_pos_i`.
- `mem_read_data_i` in 32: from `memory.read_data_o`.
- `mem_read_valid_i` in 1: from `memory.read_valid_o`.
- `mem_write_en_o` out 1: to `memory.write_en_i`.
- `mem_write_pos_o` out $clog2(DEPTH): to `memory.write_pos_i`.
- `mem_write_data_o` out 32: to `memory.write_data_i`.

## Operation
States: IDLE, READ, WAIT, WRITE, RESP.
- **IDLE**
  - `req_ready_o`=1; all other outputs are inactive.
  - On accept, latch the request fields.
  - A load, or a store with size ≠ word, goes to READ.
  - A word store goes to WRITE.
  - A rejected request (see Configuration) goes to RESP with error set.
- **READ**
  - `mem_read_en_o`=1 for exactly one cycle.
  - `mem_read_pos_o` = addr[ADDR_W-1:2].
  - Always goes to WAIT next.
- **WAIT**
  - Holds until `mem_read_valid_i`=1.
  - On valid, capture `mem_read_data_i`.
  - A load goes to RESP. A sub-word store goes to WRITE.
  - `mem_read_valid_i` is ignored in every other state.
- **WRITE**
  - `mem_write_en_o`=1 for exactly one cycle.
  - `mem_write_pos_o` = addr[ADDR_W-1:2].
  - Data for a word store is `req_wdata_i` as latched.
  - Data for a sub-word store is the captured word with the target lane replaced.
  - Always goes to RESP next.
- **RESP**
  - `rsp_valid_o`=1 for one cycle, then IDLE.
  - There is no response back-pressure.
- **Lanes**
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Byte store writes `wdata[7:0]` into lane `8*addr[1:0]`. Half store writes `wdata[15:0]` into lane `16*addr[1]`.
  - Loads right-justify the selected lane, then sign- or zero-extend it to 32 bits per `req_unsigned_i`.
- **Arithmetic**
  - No carries, and no address overflow checks.
  - Position wraps naturally within $clog2(DEPTH) bits.
- **Reset**
  - All outputs go to 0, except `req_ready_o`, which is 0 during reset and 1 in the first cycle after `rst_i` falls.
  - `mem_*_pos_o` and `mem_write_data_o` reset to 0 and otherwise hold their last value.
  - Reset in any state aborts the transaction. No write is issued, and no response is sent for it.

## Timing
Let T be the accept cycle (`req_valid_i` and `req_ready_o` both high).
- **Word store:** WRITE at T+1, RESP at T+2.
- **Load:** READ at T+1. With memory latency L ≥ 1 (valid L cycles after `read_en`), RESP is at T+2+L; for L=1, RESP is at T+3.
- **Sub-word store:** READ at T+1; WRITE at T+2+L, which is the cycle after valid; RESP at T+3+L.
- **Rejected request:** RESP at T+1, with no memory activity.
- **Next request:** it may be accepted in the cycle after RESP. Throughput is one request in flight.

## Configuration
- **`MEM_REQUESTER_MISALIGN_TRAP_EN` defined:**
  - The following are rejected with `rsp_err_o`=1 and `rsp_rdata_o`=0, and are never sent to memory: size 11; half with addr[0]=1; word with addr[1:0]≠0.
- **Not defined:**
  - `rsp_err_o` is tied to 0.
  - Size 11 is treated as word.
  - Misaligned low address bits are ignored: half ignores addr[0]; word ignores addr[1:0].

## Test plan
1. **Word store:** addr 0x14, data 0x45. Expect `mem_write_en_o` high only at T+1 with pos 5 and data 0x45, and `rsp_valid_o` at T+2 with err 0.
2. **Word load:** addr 0x14, memory L=1 returning 0x45. Expect one `mem_read_en_o` pulse at T+1 with pos 5, and rsp at T+3 with rdata 0x00000045.
3. **Byte store, read-modify-write:** store 0xAB to addr 0x16 over stored word 0x11223344. Expect a read of pos 5, then a write of 0x11AB3344 to pos 5.
4. **Sign extension:** stored word 0x80FF0000.
   - Signed byte load at 0x17 → 0xFFFFFF80.
   - Unsigned byte load at 0x17 → 0x00000080.
   - Signed half load at 0x16 → 0xFFFF80FF.
5. **Misaligned word load at 0x15:**
   - With the macro: rsp at T+1 with err 1 and rdata 0, and no `mem_read_en_o`.
   - Without the macro: reads pos 5, err 0.
6. **Reset mid-transaction:** raise `rst_i` while in WAIT during a byte store. Expect all outputs at 0, no `mem_write_en_o` ever, and `req_ready_o`=1 in the first cycle after reset drops.
